// File: rtl/aes_pkg.sv
// Shared types and constants for the AES SPI front end.
// Widths here match the default 128-bit key and block.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RX, WAIT_DONE, TX} spi_state_t;

  localparam int FRAME_BITS  = 256;
  localparam int RESULT_BITS = 128;
  localparam int CNT_W       = 9;

  // The bit counter saturates so a runaway frame can never wrap back to a legal count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/aes_spi_frontend_sync_edge.sv
// Multi-flop pin synchronizer with one extra flop for rise/fall strobes.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave feeding key/plaintext frames to the AES controller and
// returning the ciphertext to the MCU, all in the clk domain.
module aes_spi_frontend
  import aes_pkg::*;
#(
  parameter int KEY_W       = 128,
  parameter int TXT_W       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             sdi,
  input  logic             ce,
  output logic             sdo,
  input  logic             core_done,
  input  logic [TXT_W-1:0] cyphertext,
  output logic             load,
  output logic [KEY_W-1:0] key,
  output logic [TXT_W-1:0] plaintext,
  output logic             done,
  output logic             frame_err
);

  localparam int               FRAME_W    = KEY_W + TXT_W;
  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] RESULT_CNT = CNT_W'(TXT_W);

  logic sck_rise, sck_fall, sdi_s, ce_rise, ce_fall;
  logic sck_s_unused, ce_s_unused, sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d(sck),
    .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset_n(reset_n), .d(sdi),
    .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk(clk), .reset_n(reset_n), .d(ce),
    .q(ce_s_unused), .rise(ce_rise), .fall(ce_fall)
  );

  spi_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [TXT_W-1:0] tx_shift_q, tx_shift_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [TXT_W-1:0] pt_q, pt_d;
  logic sdo_q, sdo_d, load_q, load_d, load_pend_q, load_pend_d;
  logic done_q, done_d, frame_err_q, frame_err_d;
  logic core_done_prev_q, core_done_prev_d, core_done_rise;

  assign core_done_rise = core_done & ~core_done_prev_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rx_shift_d       = rx_shift_q;
    tx_shift_d       = tx_shift_q;
    key_d            = key_q;
    pt_d             = pt_q;
    sdo_d            = sdo_q;
    done_d           = done_q;
    load_d           = 1'b0;
    load_pend_d      = 1'b0;
    frame_err_d      = 1'b0;
    core_done_prev_d = core_done;

    // Capture happens one cycle after the accepting ce_fall so a same-cycle final shift lands first.
    if (load_pend_q) begin
      key_d  = rx_shift_q[FRAME_W-1:TXT_W];
      pt_d   = rx_shift_q[TXT_W-1:0];
      load_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (ce_rise) begin
          cnt_d      = '0;
          rx_shift_d = '0;
          done_d     = 1'b0;
          state_d    = RX;
        end
      end
      RX: begin
        if (sck_rise) begin
          rx_shift_d = {rx_shift_q[FRAME_W-2:0], sdi_s};
          cnt_d      = sat_inc(cnt_q);
        end
        if (ce_fall) begin
          if (cnt_d == FRAME_CNT) begin
            load_pend_d = 1'b1;
            state_d     = WAIT_DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (ce_rise) begin
          cnt_d      = '0;
          rx_shift_d = '0;
          done_d     = 1'b0;
          state_d    = RX;
        end else if (core_done_rise) begin
          tx_shift_d = cyphertext;
          sdo_d      = cyphertext[TXT_W-1];
          cnt_d      = '0;
          done_d     = 1'b1;
          state_d    = TX;
        end
      end
      TX: begin
        if (ce_rise) begin
          cnt_d      = '0;
          rx_shift_d = '0;
          done_d     = 1'b0;
          state_d    = RX;
        end else if (sck_fall) begin
          tx_shift_d = {tx_shift_q[TXT_W-2:0], 1'b0};
          sdo_d      = tx_shift_q[TXT_W-2];
          cnt_d      = sat_inc(cnt_q);
          if (cnt_d == RESULT_CNT) begin
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      rx_shift_q       <= '0;
      tx_shift_q       <= '0;
      key_q            <= '0;
      pt_q             <= '0;
      sdo_q            <= 1'b0;
      done_q           <= 1'b0;
      load_q           <= 1'b0;
      load_pend_q      <= 1'b0;
      frame_err_q      <= 1'b0;
      core_done_prev_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rx_shift_q       <= rx_shift_d;
      tx_shift_q       <= tx_shift_d;
      key_q            <= key_d;
      pt_q             <= pt_d;
      sdo_q            <= sdo_d;
      done_q           <= done_d;
      load_q           <= load_d;
      load_pend_q      <= load_pend_d;
      frame_err_q      <= frame_err_d;
      core_done_prev_q <= core_done_prev_d;
    end
  end

  assign sdo       = sdo_q;
  assign load      = load_q;
  assign key       = key_q;
  assign plaintext = pt_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Self-checking bench for aes_spi_frontend: table of frames checked against
// a bit-list reference model, plus hand-written readback/abort/reset sequences.
module tb_aes_spi_frontend;

  localparam int KEY_W       = 128;
  localparam int TXT_W       = 128;
  localparam int SYNC_STAGES = 2;
  localparam int NVEC        = 8;

  logic clk, reset_n, sck, sdi, ce, sdo, core_done, load, done, frame_err;
  logic [TXT_W-1:0] cyphertext, plaintext;
  logic [KEY_W-1:0] key;

  aes_spi_frontend #(.KEY_W(KEY_W), .TXT_W(TXT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce), .sdo(sdo),
    .core_done(core_done), .cyphertext(cyphertext), .load(load), .key(key),
    .plaintext(plaintext), .done(done), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int load_cnt = 0;
  int err_cnt = 0;
  int last_load_cyc = 0;
  int ce_fall_cyc = 0;
  int pass_cnt = 0;
  int check_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every cycle load or frame_err is seen high.
  always @(negedge clk) begin
    if (load) begin
      load_cnt      <= load_cnt + 1;
      last_load_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    int           nbits;
    logic [319:0] frame;
    logic         exp_load;
    logic         exp_err;
    logic [127:0] exp_key;
    logic [127:0] exp_pt;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [319:0] randFrame();
    logic [319:0] f;
    for (int k = 0; k < 10; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  // Reference model: the MCU's bit list is accepted only if it is exactly 256
  // long; then the first 128 bits are the key and the rest the plaintext.
  task automatic modelFrame(input int nbits, input logic [319:0] frame,
                            inout logic [127:0] mk, inout logic [127:0] mp,
                            output logic el, output logic ee);
    bit bits[$];
    for (int i = 0; i < nbits; i++) bits.push_back(frame[319-i]);
    el = (bits.size() == 256);
    ee = !el;
    if (el) begin
      for (int j = 0; j < 128; j++) begin
        mk[127-j] = bits[j];
        mp[127-j] = bits[128+j];
      end
    end
  endtask

  // Sends frame bits MSB first: bit i is frame[319-i]; sdi changes while sck is low.
  task automatic applyStimulus(input int nbits, input logic [319:0] frame, input bit end_frame);
    @(negedge clk);
    ce = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = frame[319-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    if (end_frame) begin
      repeat (4) @(negedge clk);
      ce = 1'b0;
      ce_fall_cyc = cyc;
      repeat (10) @(negedge clk);
    end
  endtask

  // MCU read: sample sdo at each sck rising edge.
  task automatic readBits(input int n, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {got[126:0], sdo};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulseCoreDone(input logic [127:0] ct);
    @(negedge clk);
    cyphertext = ct;
    checkOutput("done_before_core_done", 256'(done), 256'(1'b0));
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    checkOutput("done_one_clk_after", 256'(done), 256'(1'b1));
  endtask

  logic [127:0] mk, mp, got, ct;
  logic [319:0] fr;
  logic el, ee;
  int ld0, er0;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; ce = 1'b0; core_done = 1'b0; cyphertext = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_load", 256'(load), 256'(1'b0));
    checkOutput("reset_key", 256'(key), 256'(0));
    checkOutput("reset_pt", 256'(plaintext), 256'(0));
    checkOutput("reset_done", 256'(done), 256'(1'b0));
    checkOutput("reset_frame_err", 256'(frame_err), 256'(1'b0));
    checkOutput("reset_sdo", 256'(sdo), 256'(1'b0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0].nbits = 256;
    vecs[0].frame = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 64'h0};
    vecs[1].nbits = 255; vecs[1].frame = randFrame();
    vecs[2].nbits = 257; vecs[2].frame = randFrame();
    vecs[3].nbits = 256; vecs[3].frame = randFrame();
    vecs[4].nbits = 10;  vecs[4].frame = randFrame();
    for (int v = 5; v < NVEC; v++) begin
      vecs[v].nbits = 255 + int'($urandom_range(0, 2));
      vecs[v].frame = randFrame();
    end
    mk = '0; mp = '0;
    for (int v = 0; v < NVEC; v++) begin
      modelFrame(vecs[v].nbits, vecs[v].frame, mk, mp, el, ee);
      vecs[v].exp_load = el; vecs[v].exp_err = ee;
      vecs[v].exp_key = mk; vecs[v].exp_pt = mp;
    end

    for (int v = 0; v < NVEC; v++) begin
      ld0 = load_cnt; er0 = err_cnt;
      applyStimulus(vecs[v].nbits, vecs[v].frame, 1'b1);
      checkOutput($sformatf("vec%0d_load_count", v), 256'(load_cnt - ld0), 256'(vecs[v].exp_load));
      checkOutput($sformatf("vec%0d_err_count", v), 256'(err_cnt - er0), 256'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d_key", v), 256'(key), 256'(vecs[v].exp_key));
      checkOutput($sformatf("vec%0d_pt", v), 256'(plaintext), 256'(vecs[v].exp_pt));
      if (vecs[v].exp_load)
        checkOutput($sformatf("vec%0d_load_latency", v), 256'(last_load_cyc - ce_fall_cyc), 256'(SYNC_STAGES + 2));
    end

    // Readback of the known ciphertext, MSB first, then done clears and core_done is ignored.
    ld0 = load_cnt;
    applyStimulus(256, vecs[0].frame, 1'b1);
    checkOutput("readback_frame_load", 256'(load_cnt - ld0), 256'(1));
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pulseCoreDone(ct);
    readBits(128, got);
    checkOutput("readback_data", 256'(got), 256'(ct));
    repeat (6) @(negedge clk);
    checkOutput("readback_done_cleared", 256'(done), 256'(1'b0));
    core_done = 1'b1;
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_tx_ignores_core_done", 256'(done), 256'(1'b0));

    // Abort after 40 bits of TX: a new frame then loads normally.
    ld0 = load_cnt;
    applyStimulus(256, vecs[3].frame, 1'b1);
    checkOutput("abort_first_load", 256'(load_cnt - ld0), 256'(1));
    ct = {$urandom, $urandom, $urandom, $urandom};
    pulseCoreDone(ct);
    readBits(40, got);
    checkOutput("abort_partial_read", 256'(got[39:0]), 256'(ct[127:88]));
    @(negedge clk);
    ce = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_done_dropped", 256'(done), 256'(1'b0));
    fr = randFrame();
    mk = key; mp = plaintext;
    modelFrame(256, fr, mk, mp, el, ee);
    ld0 = load_cnt; er0 = err_cnt;
    applyStimulus(256, fr, 1'b1);
    checkOutput("abort_new_frame_load", 256'(load_cnt - ld0), 256'(1));
    checkOutput("abort_new_frame_err", 256'(err_cnt - er0), 256'(0));
    checkOutput("abort_new_frame_key", 256'(key), 256'(mk));
    checkOutput("abort_new_frame_pt", 256'(plaintext), 256'(mp));

    // Asynchronous reset in the middle of a frame.
    ld0 = load_cnt; er0 = err_cnt;
    applyStimulus(100, randFrame(), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrx_reset_key", 256'(key), 256'(0));
    checkOutput("midrx_reset_pt", 256'(plaintext), 256'(0));
    checkOutput("midrx_reset_flags", 256'({load, done, frame_err, sdo}), 256'(0));
    ce = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrx_reset_no_load", 256'(load_cnt - ld0), 256'(0));
    checkOutput("midrx_reset_no_err", 256'(err_cnt - er0), 256'(0));
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stray_core_done_idle", 256'(done), 256'(1'b0));
    fr = randFrame();
    mk = '0; mp = '0;
    modelFrame(256, fr, mk, mp, el, ee);
    ld0 = load_cnt;
    applyStimulus(256, fr, 1'b1);
    checkOutput("post_reset_load", 256'(load_cnt - ld0), 256'(1));
    checkOutput("post_reset_key", 256'(key), 256'(mk));
    checkOutput("post_reset_pt", 256'(plaintext), 256'(mp));
    checkOutput("post_reset_latency", 256'(last_load_cyc - ce_fall_cyc), 256'(SYNC_STAGES + 2));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
